// File: rtl/arm_data_memory_ws.sv
// Word-organised data memory with WAIT_CYCLES wait states and valid/ready request/response channels.
// Optional misaligned-access detection is enabled by defining ARM_DMEM_ALIGN_CHECK_EN.
module arm_data_memory_ws #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam int          BE_W      = DATA_WIDTH / 8;
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  write_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_W-1:0]       be_q;
    logic                  mis_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    logic                  req_mis;
    logic [IDX_W-1:0]      req_idx;
    logic                  accept;
    logic                  acc_fire;
    logic                  acc_write;
    logic [IDX_W-1:0]      acc_idx;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [BE_W-1:0]       acc_be;
    logic                  acc_mis;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  mem_we;

`ifdef ARM_DMEM_ALIGN_CHECK_EN
    assign req_mis = (req_addr[1:0] != 2'b00);
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:IDX_W+2]};
`else
    assign req_mis = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:IDX_W+2], req_addr[1:0]};
`endif

    assign req_idx = req_addr[IDX_W+1:2];
    assign accept  = (state_q == ST_IDLE) && req_valid;

    // With zero wait states the access happens on the accept edge, so it must use the live request.
    always_comb begin
        acc_write = write_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        acc_mis   = mis_q;
        if (state_q == ST_IDLE) begin
            acc_write = req_write;
            acc_idx   = req_idx;
            acc_wdata = req_wdata;
            acc_be    = req_be;
            acc_mis   = req_mis;
        end
        acc_fire = (ZERO_WAIT && accept) || ((state_q == ST_WAIT) && (cnt_q == 4'd0));
    end

    assign old_word = mem[acc_idx];

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_byte_merge
            assign merged_word[8*gi +: 8] = (acc_write && acc_be[gi]) ? acc_wdata[8*gi +: 8]
                                                                      : old_word[8*gi +: 8];
        end
    endgenerate

    assign rsp_rdata_d = acc_mis ? '0 : merged_word;
    // Gating with reset_n keeps a write that coincides with reset from landing.
    assign mem_we      = acc_fire && acc_write && !acc_mis && reset_n;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= merged_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            mis_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        write_q     <= req_write;
                        idx_q       <= req_idx;
                        wdata_q     <= req_wdata;
                        be_q        <= req_be;
                        mis_q       <= req_mis;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (ZERO_WAIT) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rsp_rdata_d;
                            rsp_err_q   <= acc_mis;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= acc_mis;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_arm_data_memory_ws.sv
// Self-checking bench for arm_data_memory_ws: directed vector table, stall/reset sequences and
// randomized traffic against a word-array reference model.
module tb_arm_data_memory_ws;

    localparam int WAITS = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [256];

    arm_data_memory_ws #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (256),
        .WAIT_CYCLES(WAITS)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: memory is a plain word array; misaligned accesses are rejected only with the check enabled.
    task automatic model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] exp_rdata, output logic exp_err);
        int idx;
        logic misaligned;
        idx = int'((addr / 4) % 256);
`ifdef ARM_DMEM_ALIGN_CHECK_EN
        misaligned = (addr % 4) != 0;
`else
        misaligned = 1'b0;
`endif
        if (misaligned) begin
            exp_rdata = 32'h0;
            exp_err   = 1'b1;
        end else begin
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
            exp_rdata = ref_mem[idx];
            exp_err   = 1'b0;
        end
    endtask

    // lat = number of rising edges after the accept edge up to the first one that sees rsp_valid high.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err,
                       output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs [8];
        logic [31:0] rd;
        logic [31:0] exp_rd;
        logic        er;
        logic        exp_er;
        logic [31:0] held;
        int          lat;
        int          guard;
        int          n_wr;
        int          n_rd;

        vecs[0] = '{1'b1, 32'h10,  32'hdeadbeef, 4'hf, 32'hdeadbeef, 1'b0};
        vecs[1] = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hdeadbeef, 1'b0};
        vecs[2] = '{1'b1, 32'h10,  32'h11223344, 4'h5, 32'hde22be44, 1'b0};
        vecs[3] = '{1'b0, 32'h10,  32'h0,        4'hf, 32'hde22be44, 1'b0};
        vecs[4] = '{1'b1, 32'h400, 32'hcafef00d, 4'hf, 32'hcafef00d, 1'b0};
        vecs[5] = '{1'b0, 32'h000, 32'h0,        4'h0, 32'hcafef00d, 1'b0};
        vecs[6] = '{1'b1, 32'h10,  32'h99999999, 4'h0, 32'hde22be44, 1'b0};
`ifdef ARM_DMEM_ALIGN_CHECK_EN
        vecs[7] = '{1'b1, 32'h13,  32'haabbccdd, 4'hf, 32'h00000000, 1'b1};
`else
        vecs[7] = '{1'b1, 32'h13,  32'haabbccdd, 4'hf, 32'haabbccdd, 1'b0};
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        reset_n = 1'b1;

        // Fill the whole memory through the port so the model knows every word
        for (int i = 0; i < 256; i++) begin
            logic [31:0] d;
            d = $urandom;
            txn(1'b1, 32'(i * 4), d, 4'hf, rd, er, lat);
            model(1'b1, 32'(i * 4), d, 4'hf, exp_rd, exp_er);
            chk($sformatf("fill_%0d", i), rd, exp_rd);
        end

        // Directed vector table
        for (int v = 0; v < 8; v++) begin
            txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be, rd, er, lat);
            model(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be, exp_rd, exp_er);
            chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
            chk($sformatf("vec%0d_err", v), {31'b0, er}, {31'b0, vecs[v].exp_err});
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(WAITS + 1));
        end
`ifdef ARM_DMEM_ALIGN_CHECK_EN
        chk("misaligned_mem4", dut.mem[4], 32'hde22be44);
`else
        chk("misaligned_mem4", dut.mem[4], 32'haabbccdd);
`endif

        // Stalled response with a competing request held on the request channel
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        @(negedge clk);
        req_write = 1'b1;
        req_wdata = 32'h55555555;
        req_be    = 4'hf;
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        held = ref_mem[4];
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("stall%0d_valid", c), {31'b0, rsp_valid}, 32'd1);
            chk($sformatf("stall%0d_rdata", c), rsp_rdata, held);
            chk($sformatf("stall%0d_req_ready", c), {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("stall_post_valid", {31'b0, rsp_valid}, 32'd0);
        chk("stall_post_rdata_kept", rsp_rdata, held);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall_no_extra_rsp%0d", c), {31'b0, rsp_valid}, 32'd0);
        end
        txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("stall_ignored_write", rd, held);

        // Reset pulse while a write sits in WAIT
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = ~ref_mem[8];
        req_be    = 4'hf;
        @(negedge clk);
        req_valid = 1'b0;
        chk("midrst_busy_before", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("midrst_no_rsp%0d", c), {31'b0, rsp_valid}, 32'd0);
        end
        chk("midrst_mem8", dut.mem[8], ref_mem[8]);

        // Randomized traffic against the model
        n_wr = 0;
        n_rd = 0;
        for (int t = 0; t < 80; t++) begin
            logic        wr;
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  be;
            wr = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 4095));
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            if (wr) n_wr++; else n_rd++;
            txn(wr, a, d, be, rd, er, lat);
            model(wr, a, d, be, exp_rd, exp_er);
            $display("txn %0d: %s addr=%h wdata=%h be=%h rdata=%h err=%0d lat=%0d", t,
                     wr ? "WR" : "RD", a, d, be, rd, er, lat);
            chk($sformatf("rand%0d_rdata", t), rd, exp_rd);
            chk($sformatf("rand%0d_err", t), {31'b0, er}, {31'b0, exp_er});
            chk($sformatf("rand%0d_latency", t), 32'(lat), 32'(WAITS + 1));
        end
        $display("random traffic: %0d writes, %0d reads", n_wr, n_rd);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
